micro_sequencer: RTL and testbench
==================================

// Module: micro_sequencer
// PURPOSE
//  Parametrised microprogram sequencer, next generation of the micro-alpha control path.
//  Holds the micro-PC and drives the control-memory address. Adds a subroutine return stack,
//  opcode dispatch and condition-select branching. Stalls on input/output FIFO handshakes.
//  Sits between control memory and the micro-op decode; datapath supplies conditions and dispatch address.
// PARAMETERS
//  CA_W         12       control-memory address width
//  ENTRY_POINT  12'h101  micro-PC value after reset (CA_W bits)
//  STACK_DEPTH  4        return-stack entries (>=1)
//  COND_N       8        number of condition inputs
// PORTS
//  clk           in   1                clock; all state on rising edge
//  rst           in   1                synchronous, active-low reset
//  seq_op        in   3                seq_op_t from current control word
//  seq_target    in   CA_W             jump/branch/call target
//  cond_sel      in   $clog2(COND_N)   condition index for BRANCH
//  cond_pol      in   1                1: branch if cond true; 0: branch if cond false
//  cond          in   COND_N           datapath status flags (Z, N, OV, ...)
//  dispatch_addr in   CA_W             opcode-mapped entry from datapath
//  io_rd         in   1                current word consumes one input-FIFO byte
//  io_wr         in   1                current word produces one output-FIFO byte
//  if_empty      in   1                input FIFO empty
//  of_full       in   1                output FIFO full
//  cm_addr       out  CA_W             control-memory address (= micro-PC)
//  if_re         out  1                input FIFO read strobe
//  of_we         out  1                output FIFO write strobe
//  stall         out  1                current word held this cycle
//  led_hlt       out  1                sequencer halted (sticky)
//  stack_ovf     out  1                CALL with full stack (sticky)
//  stack_unf     out  1                RETURN with empty stack (sticky)
// BEHAVIOUR
//  - Control memory reads combinationally; one control word executes per cycle unless stalled.
//  - Reset (rst=0 at edge): upc=ENTRY_POINT, sp=0, led_hlt=stack_ovf=stack_unf=0.
//    if_re, of_we and stall are forced to 0 while rst=0. Reset overrides stall, halt and any op.
//  - stall = (io_rd & if_empty) | (io_wr & of_full). A stalled word makes no state change:
//    upc holds, no push/pop, and if_re and of_we are both 0 (no partial I/O).
//  - if_re = io_rd & ~stall & ~led_hlt; of_we = io_wr & ~stall & ~led_hlt.
//    Each strobe is 1 cycle per executed word.
//  - Next upc when not stalled and not halted, by seq_op:
//      NEXT   upc+1, mod 2^CA_W (0xFFF wraps to 0x000)
//      JUMP   seq_target
//      BRANCH (cond[cond_sel]==cond_pol) ? seq_target : upc+1
//      CALL   push upc+1, upc=seq_target. If sp==STACK_DEPTH: no push, stack_ovf=1, led_hlt=1
//      RETURN upc=pop. If sp==0: stack_unf=1, led_hlt=1
//      DISPATCH upc=dispatch_addr
//      HALT   led_hlt=1
//      other  treated as NEXT
//  - Halted: upc frozen at the halting word's address, strobes 0, sticky until reset.
//  - Stack is LIFO; sp counts 0..STACK_DEPTH. A CALL at the last free slot fills the stack legally.
//  - cond_sel >= COND_N reads as condition 0.
// STRUCTURE
//  - micro_seq_pkg: seq_op_t enum {NEXT=0,JUMP,BRANCH,CALL,RETURN,DISPATCH,HALT} and default CA_W.
//  - Sub-module micro_seq_stack (push/pop/full/empty, STACK_DEPTH x CA_W regs).
//  - Top holds the upc register, next-address mux, stall logic and sticky flags.
// TESTING
//  1 reset low 2 cycles, then NEXT x3 -> cm_addr 0x101,0x102,0x103,0x104; all flags 0.
//  2 CALL 0x200 at 0x105, NEXT, RETURN -> 0x200,0x201,0x106; sp back to 0.
//  3 5 nested CALLs, STACK_DEPTH=4 -> stack_ovf=1, led_hlt=1, cm_addr frozen at the 5th CALL's address.
//  4 io_rd=1 with if_empty=1 for 3 cycles, then 0 -> stall=1 and if_re=0 for 3 cycles;
//    then exactly one if_re pulse and upc advances.
//  5 BRANCH cond_sel=2 pol=1: cond[2]=1 -> seq_target; cond[2]=0 -> upc+1.
//    NEXT at 0xFFF -> 0x000.
//  6 rst=0 during an of_full stall or while halted -> next cycle cm_addr=0x101, flags clear, of_we=0.

Source files
------------

// File: rtl/micro_seq_pkg.sv
// Shared types and defaults for the micro-sequencer slice.
//   seq_op_t    : sequencing operation carried in each control word
//   run_state_t : run/halt state of the sequencer control FSM
//   CA_W_DEFAULT: default control-memory address width
package micro_seq_pkg;

    localparam int CA_W_DEFAULT = 12;

    typedef enum logic [2:0] {
        OP_NEXT     = 3'd0,
        OP_JUMP     = 3'd1,
        OP_BRANCH   = 3'd2,
        OP_CALL     = 3'd3,
        OP_RETURN   = 3'd4,
        OP_DISPATCH = 3'd5,
        OP_HALT     = 3'd6
    } seq_op_t;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } run_state_t;

endpackage

// File: rtl/micro_seq_stack.sv
// LIFO return-address stack for the micro-sequencer.
//   clk, rst   : clock, synchronous active-low reset (empties the stack)
//   push, pop  : requests; push is ignored when full, pop when empty
//   push_data  : return address to store
//   top_data   : most recently pushed entry (valid when not empty)
//   full/empty : occupancy status
module micro_seq_stack
    import micro_seq_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = CA_W_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] push_data,
    output logic [W-1:0] top_data,
    output logic         full,
    output logic         empty
);

    // sp counts 0..DEPTH, so it needs one more code than the entry count.
    localparam int SP_W = $clog2(DEPTH + 1);

    logic [SP_W-1:0] sp;
    logic [W-1:0]    entries [DEPTH];
    logic            do_push;
    logic            do_pop;

    assign full    = (sp == SP_W'(DEPTH));
    assign empty   = (sp == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_ff @(posedge clk) begin
        if (!rst) begin
            sp <= '0;
        end else if (do_push) begin
            sp <= sp + SP_W'(1);
        end else if (do_pop) begin
            sp <= sp - SP_W'(1);
        end
    end

    // Entries need no reset: sp alone defines which ones are valid.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (rst && do_push && (sp == SP_W'(i))) begin
                entries[i] <= push_data;
            end
        end
    end

    // Compare-based read keeps the index width independent of DEPTH.
    always_comb begin
        top_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (sp == SP_W'(i + 1)) begin
                top_data = entries[i];
            end
        end
    end

endmodule

// File: rtl/micro_sequencer.sv
// Microprogram sequencer: holds the micro-PC, drives the control-memory
// address, and resolves next-address selection (next, jump, conditional
// branch, call/return via a return stack, opcode dispatch, halt). Words
// that need an unavailable FIFO are held without any side effect.
//
// State table (run/halt FSM)
//   state   | meaning
//   ST_RUN  | executing one control word per cycle unless stalled
//   ST_HALT | frozen at halting word; strobes off; left only by reset
//
// Ports
//   clk, rst          : clock, synchronous active-low reset
//   seq_op            : sequencing op (seq_op_t) of current word
//   seq_target        : jump/branch/call target
//   cond_sel/cond_pol : condition index and polarity for BRANCH
//   cond              : datapath status flags
//   dispatch_addr     : opcode-mapped entry address
//   io_rd/io_wr       : current word consumes/produces a FIFO byte
//   if_empty/of_full  : FIFO status
//   cm_addr           : control-memory address (micro-PC)
//   if_re/of_we       : FIFO strobes, one per executed word
//   stall             : current word held this cycle
//   led_hlt           : halted (sticky)
//   stack_ovf/unf     : CALL on full / RETURN on empty stack (sticky)
module micro_sequencer
    import micro_seq_pkg::*;
#(
    parameter int              CA_W        = CA_W_DEFAULT,
    parameter logic [CA_W-1:0] ENTRY_POINT = CA_W'(12'h101),
    parameter int              STACK_DEPTH = 4,
    parameter int              COND_N      = 8,
    parameter int              CS_W        = (COND_N > 1) ? $clog2(COND_N) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [2:0]      seq_op,
    input  logic [CA_W-1:0] seq_target,
    input  logic [CS_W-1:0] cond_sel,
    input  logic            cond_pol,
    input  logic [COND_N-1:0] cond,
    input  logic [CA_W-1:0] dispatch_addr,
    input  logic            io_rd,
    input  logic            io_wr,
    input  logic            if_empty,
    input  logic            of_full,
    output logic [CA_W-1:0] cm_addr,
    output logic            if_re,
    output logic            of_we,
    output logic            stall,
    output logic            led_hlt,
    output logic            stack_ovf,
    output logic            stack_unf
);

    run_state_t      state;
    run_state_t      state_nxt;
    seq_op_t         op;
    logic [CA_W-1:0] upc;
    logic [CA_W-1:0] upc_inc;
    logic [CA_W-1:0] upc_nxt;
    logic            exec;
    logic            cond_bit;
    logic            push;
    logic            pop;
    logic            halt_evt;
    logic            ovf_evt;
    logic            unf_evt;
    logic [CA_W-1:0] stk_top;
    logic            stk_full;
    logic            stk_empty;

    assign op      = seq_op_t'(seq_op);
    assign upc_inc = upc + CA_W'(1);
    assign cm_addr = upc;

    micro_seq_stack #(
        .DEPTH (STACK_DEPTH),
        .W     (CA_W)
    ) u_stack (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .pop       (pop),
        .push_data (upc_inc),
        .top_data  (stk_top),
        .full      (stk_full),
        .empty     (stk_empty)
    );

    // Out-of-range selects fall through to condition 0.
    always_comb begin
        cond_bit = cond[0];
        for (int i = 1; i < COND_N; i++) begin
            if (cond_sel == CS_W'(i)) begin
                cond_bit = cond[i];
            end
        end
    end

    // FSM: state register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= ST_RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM: next state
    always_comb begin
        state_nxt = state;
        if ((state == ST_RUN) && halt_evt) begin
            state_nxt = ST_HALT;
        end
    end

    // FSM: outputs. Reset masks stall and strobes so nothing leaks out
    // of a word that is being discarded.
    always_comb begin
        led_hlt = (state == ST_HALT);
        stall   = rst & ((io_rd & if_empty) | (io_wr & of_full));
        exec    = rst & ~stall & ~led_hlt;
        if_re   = io_rd & exec;
        of_we   = io_wr & exec;
    end

    // Next-address selection. Halting ops leave upc on the halting word.
    always_comb begin
        upc_nxt  = upc;
        push     = 1'b0;
        pop      = 1'b0;
        halt_evt = 1'b0;
        ovf_evt  = 1'b0;
        unf_evt  = 1'b0;
        if (exec) begin
            case (op)
                OP_JUMP:     upc_nxt = seq_target;
                OP_BRANCH:   upc_nxt = (cond_bit == cond_pol) ? seq_target : upc_inc;
                OP_CALL: begin
                    if (stk_full) begin
                        ovf_evt  = 1'b1;
                        halt_evt = 1'b1;
                    end else begin
                        push    = 1'b1;
                        upc_nxt = seq_target;
                    end
                end
                OP_RETURN: begin
                    if (stk_empty) begin
                        unf_evt  = 1'b1;
                        halt_evt = 1'b1;
                    end else begin
                        pop     = 1'b1;
                        upc_nxt = stk_top;
                    end
                end
                OP_DISPATCH: upc_nxt = dispatch_addr;
                OP_HALT:     halt_evt = 1'b1;
                default:     upc_nxt = upc_inc;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            upc <= ENTRY_POINT;
        end else begin
            upc <= upc_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            stack_ovf <= 1'b0;
            stack_unf <= 1'b0;
        end else begin
            if (ovf_evt) stack_ovf <= 1'b1;
            if (unf_evt) stack_unf <= 1'b1;
        end
    end

endmodule

// File: tb/tb_micro_sequencer.sv
// Directed bench for micro_sequencer with hand-computed expectations.
module tb_micro_sequencer;
    import micro_seq_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  seq_op;
    logic [11:0] seq_target;
    logic [2:0]  cond_sel;
    logic        cond_pol;
    logic [7:0]  cond;
    logic [11:0] dispatch_addr;
    logic        io_rd;
    logic        io_wr;
    logic        if_empty;
    logic        of_full;
    logic [11:0] cm_addr;
    logic        if_re;
    logic        of_we;
    logic        stall;
    logic        led_hlt;
    logic        stack_ovf;
    logic        stack_unf;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    micro_sequencer dut (
        .clk           (clk),
        .rst           (rst),
        .seq_op        (seq_op),
        .seq_target    (seq_target),
        .cond_sel      (cond_sel),
        .cond_pol      (cond_pol),
        .cond          (cond),
        .dispatch_addr (dispatch_addr),
        .io_rd         (io_rd),
        .io_wr         (io_wr),
        .if_empty      (if_empty),
        .of_full       (of_full),
        .cm_addr       (cm_addr),
        .if_re         (if_re),
        .of_we         (of_we),
        .stall         (stall),
        .led_hlt       (led_hlt),
        .stack_ovf     (stack_ovf),
        .stack_unf     (stack_unf)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_state(input string tag, input logic [11:0] a,
                             input logic l, input logic o, input logic u);
        chk({tag, ".addr"}, 32'(cm_addr), 32'(a));
        chk({tag, ".led_hlt"}, 32'(led_hlt), 32'(l));
        chk({tag, ".stack_ovf"}, 32'(stack_ovf), 32'(o));
        chk({tag, ".stack_unf"}, 32'(stack_unf), 32'(u));
    endtask

    task automatic do_op(input logic [2:0] op, input logic [11:0] tgt);
        seq_op     = op;
        seq_target = tgt;
        tick();
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick();
        rst = 1'b1;
    endtask

    initial begin
        rst           = 1'b0;
        seq_op        = OP_NEXT;
        seq_target    = '0;
        cond_sel      = '0;
        cond_pol      = 1'b0;
        cond          = '0;
        dispatch_addr = '0;
        io_rd         = 1'b1;
        io_wr         = 1'b1;
        if_empty      = 1'b1;
        of_full       = 1'b1;

        // Reset held two cycles, with FIFO requests that would stall.
        tick();
        tick();
        chk("rst.stall", 32'(stall), 32'(0));
        chk("rst.if_re", 32'(if_re), 32'(0));
        chk("rst.of_we", 32'(of_we), 32'(0));
        chk_state("rst", 12'h101, 1'b0, 1'b0, 1'b0);
        io_rd    = 1'b0;
        io_wr    = 1'b0;
        if_empty = 1'b0;
        of_full  = 1'b0;
        rst      = 1'b1;

        do_op(OP_NEXT, 12'h000);
        chk("next1", 32'(cm_addr), 32'h102);
        do_op(OP_NEXT, 12'h000);
        chk("next2", 32'(cm_addr), 32'h103);
        do_op(OP_NEXT, 12'h000);
        chk_state("next3", 12'h104, 1'b0, 1'b0, 1'b0);
        do_op(OP_NEXT, 12'h000);
        chk("next4", 32'(cm_addr), 32'h105);

        // Call / return round trip.
        do_op(OP_CALL, 12'h200);
        chk("call", 32'(cm_addr), 32'h200);
        do_op(OP_NEXT, 12'h000);
        chk("sub_next", 32'(cm_addr), 32'h201);
        do_op(OP_RETURN, 12'h000);
        chk_state("return", 12'h106, 1'b0, 1'b0, 1'b0);

        // Input FIFO empty for three cycles.
        seq_op   = OP_NEXT;
        io_rd    = 1'b1;
        if_empty = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("ifstall.stall", 32'(stall), 32'(1));
            chk("ifstall.if_re", 32'(if_re), 32'(0));
            tick();
            chk("ifstall.addr", 32'(cm_addr), 32'h106);
        end
        if_empty = 1'b0;
        #1;
        chk("ifgo.stall", 32'(stall), 32'(0));
        chk("ifgo.if_re", 32'(if_re), 32'(1));
        tick();
        chk("ifgo.addr", 32'(cm_addr), 32'h107);
        io_rd = 1'b0;
        #1;
        chk("ifdone.if_re", 32'(if_re), 32'(0));

        // Branches on cond[2].
        cond_sel = 3'd2;
        cond_pol = 1'b1;
        cond     = 8'b0000_0100;
        do_op(OP_BRANCH, 12'h300);
        chk("br_taken", 32'(cm_addr), 32'h300);
        cond = 8'b0000_0000;
        do_op(OP_BRANCH, 12'h400);
        chk("br_not_taken", 32'(cm_addr), 32'h301);
        cond_pol = 1'b0;
        cond     = 8'b1111_1011;
        do_op(OP_BRANCH, 12'h350);
        chk("br_pol0_taken", 32'(cm_addr), 32'h350);

        // Wrap at top of address space, then dispatch.
        do_op(OP_JUMP, 12'hFFE);
        chk("jump", 32'(cm_addr), 32'hFFE);
        do_op(OP_NEXT, 12'h000);
        chk("to_fff", 32'(cm_addr), 32'hFFF);
        do_op(OP_NEXT, 12'h000);
        chk("wrap", 32'(cm_addr), 32'h000);
        dispatch_addr = 12'h0AB;
        do_op(OP_DISPATCH, 12'h000);
        chk("dispatch", 32'(cm_addr), 32'h0AB);

        // Output FIFO: strobe when free, stall when full, reset mid-stall.
        seq_op = OP_NEXT;
        io_wr  = 1'b1;
        #1;
        chk("ofgo.of_we", 32'(of_we), 32'(1));
        chk("ofgo.stall", 32'(stall), 32'(0));
        of_full = 1'b1;
        #1;
        chk("ofstall.stall", 32'(stall), 32'(1));
        chk("ofstall.of_we", 32'(of_we), 32'(0));
        tick();
        chk("ofstall.addr", 32'(cm_addr), 32'h0AB);
        rst = 1'b0;
        #1;
        chk("ofrst.stall", 32'(stall), 32'(0));
        chk("ofrst.of_we", 32'(of_we), 32'(0));
        tick();
        chk_state("ofrst", 12'h101, 1'b0, 1'b0, 1'b0);
        rst     = 1'b1;
        io_wr   = 1'b0;
        of_full = 1'b0;

        // Four calls fill the stack legally, the fifth overflows.
        do_op(OP_CALL, 12'h010);
        chk("nest1", 32'(cm_addr), 32'h010);
        do_op(OP_CALL, 12'h020);
        chk("nest2", 32'(cm_addr), 32'h020);
        do_op(OP_CALL, 12'h030);
        chk("nest3", 32'(cm_addr), 32'h030);
        do_op(OP_CALL, 12'h040);
        chk_state("nest4", 12'h040, 1'b0, 1'b0, 1'b0);
        do_op(OP_CALL, 12'h050);
        chk_state("ovf", 12'h040, 1'b1, 1'b1, 1'b0);
        seq_op = OP_NEXT;
        io_rd  = 1'b1;
        io_wr  = 1'b1;
        #1;
        chk("halted.if_re", 32'(if_re), 32'(0));
        chk("halted.of_we", 32'(of_we), 32'(0));
        tick();
        chk_state("halted", 12'h040, 1'b1, 1'b1, 1'b0);
        io_rd = 1'b0;
        io_wr = 1'b0;
        do_reset();
        chk_state("hltrst", 12'h101, 1'b0, 1'b0, 1'b0);

        // Return on empty stack.
        do_op(OP_RETURN, 12'h000);
        chk_state("unf", 12'h101, 1'b1, 1'b0, 1'b1);
        do_reset();
        chk_state("unfrst", 12'h101, 1'b0, 1'b0, 1'b0);

        // Explicit HALT.
        do_op(OP_HALT, 12'h000);
        chk_state("halt", 12'h101, 1'b1, 1'b0, 1'b0);
        do_op(OP_JUMP, 12'h123);
        chk("halt_frozen", 32'(cm_addr), 32'h101);
        do_reset();
        chk_state("haltrst", 12'h101, 1'b0, 1'b0, 1'b0);

        // LIFO ordering of return addresses.
        do_op(OP_CALL, 12'h010);
        chk("lifo_c1", 32'(cm_addr), 32'h010);
        do_op(OP_CALL, 12'h020);
        chk("lifo_c2", 32'(cm_addr), 32'h020);
        do_op(OP_RETURN, 12'h000);
        chk("lifo_r1", 32'(cm_addr), 32'h011);
        do_op(OP_RETURN, 12'h000);
        chk_state("lifo_r2", 12'h102, 1'b0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
